// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done bus between a controller (master) and the serial subtractor (slave).
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
);
  // start_i is accepted only when the slave is in IDLE or DONE; done_o pulses
  // for one cycle and the result fields stay valid until the next done_o.
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] diff_o;
  logic             bout_o;
  logic             ovf_o;
  sub_state_t       state_o;

  modport master (
    output start_i, a_i, b_i, bin_i,
    input  busy_o, done_o, diff_o, bout_o, ovf_o, state_o
  );

  modport slave (
    input  start_i, a_i, b_i, bin_i,
    output busy_o, done_o, diff_o, bout_o, ovf_o, state_o
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: a - b - br.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic diff_o,
  output logic br_o
);

  assign diff_o = a_i ^ b_i ^ br_i;
  assign br_o   = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock through a single cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_diff, cell_br;

  full_subtractor u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .br_i   (br_q),
    .diff_o (cell_diff),
    .br_o   (cell_br)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          a_sh_d  = bus.a_i;
          b_sh_d  = bus.b_i;
          br_d    = bus.bin_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = {cell_diff, r_sh_q[WIDTH-1:1]};
        br_d   = cell_br;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = {cell_diff, r_sh_q[WIDTH-1:1]};
          bout_d  = cell_br;
          // br_q is the borrow into the MSB on this last bit.
          ovf_d   = br_q ^ cell_br;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.diff_o  = diff_q;
  assign bus.bout_o  = bout_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.state_o = state_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes A - B - borrow_in. It works LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart to the team's ripple full-adder datapath, and it trades latency for area. It sits behind a start/done handshake so control logic can issue operations and collect results.

Parameters:
WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  request a new subtraction; sampled only in IDLE or DONE.
a_i  input  WIDTH  minuend; captured on the accepted start.
b_i  input  WIDTH  subtrahend; captured on the accepted start.
bin_i  input  1  borrow-in; captured on the accepted start.
busy_o  output  1  high while in RUN.
done_o  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
diff_o  output  WIDTH  result A - B - bin, modulo 2^WIDTH.
bout_o  output  1  borrow out of the MSB (unsigned A < B + bin).
ovf_o  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high. Reset dominates every other input.
- Reset values: state = IDLE; busy_o = 0; done_o = 0; diff_o = 0; bout_o = 0; ovf_o = 0; internal shift registers, counter and borrow flip-flop = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start_i = 1 loads a_i and b_i into shift registers, loads bin_i into the borrow flip-flop, and clears the bit counter.
  - Next state is RUN.
- RUN:
  - The cell takes a_sh[0], b_sh[0] and the borrow flip-flop.
  - d = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d shifts into the MSB of the result shift register. The a and b registers shift right. The counter increments.
  - On the cycle that processes bit WIDTH-1, the current br value is captured as the borrow into the MSB.
  - When counter = WIDTH-1, next state is DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE (one cycle):
  - done_o = 1.
  - diff_o, bout_o and ovf_o were loaded from the result register and the final borrow on the RUN->DONE edge.
  - ovf_o = borrow-into-MSB XOR borrow-out-of-MSB.
  - If start_i = 1, new operands are captured and the next state is RUN (back-to-back operation, no idle bubble). Otherwise the next state is IDLE.
- Latency: start_i is sampled high at edge k. busy_o is high for cycles k+1 .. k+WIDTH. done_o is high in cycle k+WIDTH+1.
- Result hold: diff_o, bout_o and ovf_o hold their values until the next RUN->DONE transition or reset. They are not cleared by a new start.
- start_i during RUN is ignored. The in-flight operation is unaffected.
- Reset asserted mid-RUN aborts the operation. No done_o pulse is produced and all outputs return to their reset values.
- Operand stability: a_i, b_i and bin_i matter only in the start-accept cycle and may change freely afterwards.

Decomposition:
- Package serial_sub_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  - function cnt_w(WIDTH) = $clog2(WIDTH) for sizing the bit counter.
- One sub-module, full_subtractor: combinational cell with ports a_i, b_i, br_i, diff_o, br_o. It is instantiated once and is independently unit-testable.

Test Plan:
- Basic subtract: WIDTH=8, a=0x05, b=0x03, bin=0 -> diff_o=0x02, bout_o=0, ovf_o=0. done_o high exactly 9 cycles after the start edge; busy_o high for 8 cycles.
- Unsigned underflow: a=0x03, b=0x05, bin=0 -> diff_o=0xFE, bout_o=1, ovf_o=0.
- Signed overflow: a=0x80, b=0x01, bin=0 -> diff_o=0x7F, bout_o=0, ovf_o=1. Also a=0x7F, b=0xFF -> diff_o=0x80, bout_o=1, ovf_o=1.
- Borrow-in: a=0x00, b=0x00, bin=1 -> diff_o=0xFF, bout_o=1, ovf_o=0.
- Handshake edges:
  - Start with 0x10-0x01 at cycle 0. Pulse start_i with 0xAA/0x55 at cycle 3 (ignored). Result is 0x0F.
  - Hold start_i high in the DONE cycle with a=0x20, b=0x10. The second done_o comes 9 cycles later with diff_o=0x10. The first result (0x0F) holds until then.
- Reset mid-op: assert rst_i in the 4th RUN cycle -> the next cycle has busy_o=0, diff_o=0, bout_o=0, ovf_o=0, and no done_o pulse ever appears. A subsequent start computes correctly.
